sb_multiplier: RTL and testbench

Sequential IEEE-754 single-precision multiplier for the calculator datapath. It is the counterpart of the divider: the same 32-bit operand format, the same overflow flag, and one clock. The mantissa product is built by 24-cycle iterative shift-add, with a start/busy/done handshake. The calculator control FSM starts it for the `*` key; the result goes to the display formatter.

---
 rtl/sb_multiplier.sv | 203 ++++++++++++++++++++
 tb/tb_sb_multiplier.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/sb_multiplier.sv
// Sequential IEEE-754 single-precision multiplier: 24-cycle shift-add mantissa product, start/busy/done handshake.
// Define SB_MUL_ROUND_EN for round-to-nearest-even; otherwise the result is truncated toward zero.
`timescale 1ns/1ps

module sb_multiplier (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] result,
  output logic        busy,
  output logic        done,
  output logic        overflow,
  output logic        underflow
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_MULT   = 3'd2;
  localparam logic [2:0] S_NORM   = 3'd3;
  localparam logic [2:0] S_ROUND  = 3'd4;
  localparam logic [2:0] S_DONE   = 3'd5;

`ifdef SB_MUL_ROUND_EN
  localparam logic ROUND_EN = 1'b1;
`else
  localparam logic ROUND_EN = 1'b0;
`endif

  logic [2:0]        state_q, state_d;
  logic [31:0]       op_a_q, op_a_d;
  logic [31:0]       op_b_q, op_b_d;
  logic              sign_q, sign_d;
  logic signed [9:0] exp_q, exp_d;
  logic [47:0]       acc_q, acc_d;
  logic [4:0]        cnt_q, cnt_d;
  logic [22:0]       frac_q, frac_d;
  logic              guard_q, guard_d;
  logic              sticky_q, sticky_d;
  logic [31:0]       result_q, result_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              overflow_q, overflow_d;
  logic              underflow_q, underflow_d;

  logic [7:0]  exp_a, exp_b;
  logic [23:0] mant_a, mant_b;
  logic        a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign_now;

  assign exp_a    = op_a_q[30:23];
  assign exp_b    = op_b_q[30:23];
  assign mant_a   = {1'b1, op_a_q[22:0]};
  assign mant_b   = {1'b1, op_b_q[22:0]};
  assign a_nan    = (&exp_a) && (|op_a_q[22:0]);
  assign b_nan    = (&exp_b) && (|op_b_q[22:0]);
  assign a_inf    = (&exp_a) && !(|op_a_q[22:0]);
  assign b_inf    = (&exp_b) && !(|op_b_q[22:0]);
  // Exponent field 0 covers both zero and denormals, which are flushed.
  assign a_zero   = (exp_a == 8'd0);
  assign b_zero   = (exp_b == 8'd0);
  assign sign_now = op_a_q[31] ^ op_b_q[31];

  logic              round_up;
  logic [24:0]       mant_rnd;
  logic signed [9:0] exp_rnd;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    state_d     = state_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    sign_d      = sign_q;
    exp_d       = exp_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    frac_d      = frac_q;
    guard_d     = guard_q;
    sticky_d    = sticky_q;
    result_d    = result_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    overflow_d  = overflow_q;
    underflow_d = underflow_q;

    round_up = ROUND_EN & guard_q & (sticky_q | frac_q[0]);
    mant_rnd = {2'b01, frac_q} + {24'd0, round_up};
    exp_rnd  = mant_rnd[24] ? exp_q + 10'sd1 : exp_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          op_a_d      = a;
          op_b_d      = b;
          acc_d       = '0;
          cnt_d       = '0;
          busy_d      = 1'b1;
          overflow_d  = 1'b0;
          underflow_d = 1'b0;
          state_d     = S_UNPACK;
        end
      end
      S_UNPACK: begin
        sign_d  = sign_now;
        state_d = S_DONE;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) begin
          result_d = 32'h7FC0_0000;
        end else if (a_inf || b_inf) begin
          result_d   = {sign_now, 8'hFF, 23'd0};
          overflow_d = 1'b1;
        end else if (a_zero || b_zero) begin
          result_d = {sign_now, 31'd0};
        end else begin
          exp_d   = $signed({2'b00, exp_a}) + $signed({2'b00, exp_b}) - 10'sd127;
          state_d = S_MULT;
          done_d  = 1'b0;
          busy_d  = 1'b1;
        end
      end
      S_MULT: begin
        if (mant_b[cnt_q]) acc_d = acc_q + ({24'd0, mant_a} << cnt_q);
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'd23) state_d = S_NORM;
      end
      S_NORM: begin
        // Product of two [1,2) mantissas lies in [1,4); bit 47 marks the [2,4) case.
        if (acc_q[47]) begin
          frac_d   = acc_q[46:24];
          guard_d  = acc_q[23];
          sticky_d = |acc_q[22:0];
          exp_d    = exp_q + 10'sd1;
        end else begin
          frac_d   = acc_q[45:23];
          guard_d  = acc_q[22];
          sticky_d = |acc_q[21:0];
        end
        state_d = S_ROUND;
      end
      S_ROUND: begin
        if (exp_rnd >= 10'sd255) begin
          result_d   = {sign_q, 8'hFF, 23'd0};
          overflow_d = 1'b1;
        end else if (exp_rnd <= 10'sd0) begin
          result_d    = {sign_q, 31'd0};
          underflow_d = 1'b1;
        end else begin
          result_d = {sign_q, exp_rnd[7:0], mant_rnd[24] ? 23'd0 : mant_rnd[22:0]};
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = S_DONE;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments; all registers, datapath included, reset to a known value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      op_a_q      <= '0;
      op_b_q      <= '0;
      sign_q      <= 1'b0;
      exp_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      frac_q      <= '0;
      guard_q     <= 1'b0;
      sticky_q    <= 1'b0;
      result_q    <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      sign_q      <= sign_d;
      exp_q       <= exp_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      frac_q      <= frac_d;
      guard_q     <= guard_d;
      sticky_q    <= sticky_d;
      result_q    <= result_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign result    = result_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign overflow  = overflow_q;
  assign underflow = underflow_q;

endmodule

// File: tb/tb_sb_multiplier.sv
// Self-checking bench for sb_multiplier: directed cases, handshake, async reset, and random
// operands compared against an arithmetic reference model.
`timescale 1ns/1ps

module tb_sb_multiplier;

  localparam int LIMIT = 80;

  typedef struct packed {
    logic        special;
    logic        ovf;
    logic        unf;
    logic [31:0] res;
  } exp_t;

  logic        clk, rst_n, start;
  logic [31:0] a, b, result;
  logic        busy, done, overflow, underflow;

  int n_tests = 0;
  int n_fail  = 0;

  sb_multiplier dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .a         (a),
    .b         (b),
    .result    (result),
    .busy      (busy),
    .done      (done),
    .overflow  (overflow),
    .underflow (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic exp_t mk(input logic [31:0] res, input logic ovf, input logic unf,
                              input logic special);
    exp_t r;
    r.res = res; r.ovf = ovf; r.unf = unf; r.special = special;
    return r;
  endfunction

  // Reference: exact integer product, then normalise, round and range-check arithmetically.
  function automatic exp_t model(input logic [31:0] x, input logic [31:0] y);
    exp_t        r;
    int          ex, ey, e;
    logic        s, xnan, ynan, xinf, yinf, rnd_en, up;
    logic [63:0] p, kept, rem, half;
    r = '0;
    r.special = 1'b1;
    s  = x[31] ^ y[31];
    ex = int'(x[30:23]);
    ey = int'(y[30:23]);
    xnan = (ex == 255) && (x[22:0] != 0);
    ynan = (ey == 255) && (y[22:0] != 0);
    xinf = (ex == 255) && (x[22:0] == 0);
    yinf = (ey == 255) && (y[22:0] == 0);
`ifdef SB_MUL_ROUND_EN
    rnd_en = 1'b1;
`else
    rnd_en = 1'b0;
`endif
    if (xnan || ynan || (xinf && ey == 0) || (yinf && ex == 0)) begin
      r.res = 32'h7FC00000;
    end else if (xinf || yinf) begin
      r.res = {s, 31'd0} | 32'h7F800000;
      r.ovf = 1'b1;
    end else if (ex == 0 || ey == 0) begin
      r.res = {s, 31'd0};
    end else begin
      r.special = 1'b0;
      p = {40'd0, 1'b1, x[22:0]} * {40'd0, 1'b1, y[22:0]};
      e = ex + ey - 127;
      if (p >= (64'd1 << 47)) begin
        e++;
        kept = p >> 24; rem = p % (64'd1 << 24); half = 64'd1 << 23;
      end else begin
        kept = p >> 23; rem = p % (64'd1 << 23); half = 64'd1 << 22;
      end
      up = (rem > half) || (rem == half && kept[0]);
      if (rnd_en && up) kept++;
      if (kept == (64'd1 << 24)) begin
        kept = kept >> 1;
        e++;
      end
      if (e >= 255) begin
        r.res = {s, 31'd0} | 32'h7F800000;
        r.ovf = 1'b1;
      end else if (e <= 0) begin
        r.res = {s, 31'd0};
        r.unf = 1'b1;
      end else begin
        r.res = {s, e[7:0], kept[22:0]};
      end
    end
    return r;
  endfunction

  function automatic logic [31:0] rand_op();
    int          k;
    logic [22:0] f;
    logic        s;
    k = $urandom_range(0, 19);
    f = 23'($urandom);
    s = 1'($urandom);
    case (k)
      0:       return {s, 31'd0};
      1:       return {s, 8'hFF, 23'd0};
      2:       return {s, 8'hFF, f | 23'd1};
      3:       return {s, 8'h00, f};
      4, 5, 6: return {s, 8'($urandom_range(200, 254)), f};
      7, 8, 9: return {s, 8'($urandom_range(1, 70)), f};
      default: return {s, 8'($urandom_range(100, 154)), f};
    endcase
  endfunction

  // Called at a falling edge whose cycle number is cyc; returns at the done cycle or the bound.
  task automatic wait_done(inout int cyc, output int busy_low);
    busy_low = 0;
    while (done !== 1'b1 && cyc < LIMIT) begin
      if (busy !== 1'b1) busy_low++;
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic do_op(input logic [31:0] oa, input logic [31:0] ob, input exp_t e,
                       input string tag);
    int cyc, bl;
    @(negedge clk);
    a = oa; b = ob; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = $urandom; b = $urandom;
    cyc = 1;
    wait_done(cyc, bl);
    check({tag, " latency"}, cyc, e.special ? 2 : 28);
    check({tag, " busy gaps"}, bl, 0);
    check({tag, " busy@done"}, busy, 0);
    check({tag, " result"}, result, e.res);
    check({tag, " overflow"}, overflow, e.ovf);
    check({tag, " underflow"}, underflow, e.unf);
    @(negedge clk);
    check({tag, " done pulse"}, done, 0);
  endtask

  initial begin
    int   cyc, bl, seen;
    exp_t e;
    logic rnd_en;
`ifdef SB_MUL_ROUND_EN
    rnd_en = 1'b1;
`else
    rnd_en = 1'b0;
`endif
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    check("rst result", result, 0);
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst ovf", overflow, 0);
    check("rst unf", underflow, 0);
    rst_n = 1'b1;

    do_op(32'h40400000, 32'h40200000, mk(32'h40F00000, 0, 0, 0), "3x2.5");
    do_op(32'hBFC00000, 32'h40800000, mk(32'hC0C00000, 0, 0, 0), "-1.5x4");
    do_op(32'h00000000, 32'hC1200000, mk(32'h80000000, 0, 0, 1), "0x-10");
    do_op(32'h7F000000, 32'h7F000000, mk(32'h7F800000, 1, 0, 0), "ovf");
    do_op(32'h00800000, 32'h00800000, mk(32'h00000000, 0, 1, 0), "unf");
    do_op(32'h3FC00001, 32'h3FC00001,
          mk(rnd_en ? 32'h40100002 : 32'h40100001, 0, 0, 0), "round");
    do_op(32'h7F800000, 32'h00000000, mk(32'h7FC00000, 0, 0, 1), "infx0");
    do_op(32'h7FC00001, 32'h3F800000, mk(32'h7FC00000, 0, 0, 1), "nan");
    do_op(32'hFF800000, 32'h40000000, mk(32'hFF800000, 1, 0, 1), "-inf");

    // A second start during MULT must be ignored.
    @(negedge clk);
    a = 32'h40400000; b = 32'h40200000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (8) @(negedge clk);
    a = 32'h40000000; b = 32'h40000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 10;
    wait_done(cyc, bl);
    check("ignore latency", cyc, 28);
    check("ignore result", result, 32'h40F00000);
    repeat (3) @(negedge clk);
    check("ignore idle busy", busy, 0);

    // start held through done: the next op is accepted one cycle after the done cycle.
    @(negedge clk);
    a = 32'h40400000; b = 32'h40200000; start = 1'b1;
    @(negedge clk);
    a = 32'hBFC00000; b = 32'h40800000;
    cyc = 1;
    wait_done(cyc, bl);
    check("hold first latency", cyc, 28);
    check("hold first result", result, 32'h40F00000);
    @(negedge clk);
    cyc++;
    check("hold gap busy", busy, 0);
    check("hold gap done", done, 0);
    @(negedge clk);
    cyc++;
    start = 1'b0;
    check("hold second busy", busy, 1);
    wait_done(cyc, bl);
    check("hold second latency", cyc, 57);
    check("hold second result", result, 32'hC0C00000);
    @(negedge clk);

    // Asynchronous reset in the middle of MULT.
    @(negedge clk);
    a = 32'h7F000000; b = 32'h7F000000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (14) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst result", result, 0);
    check("arst busy", busy, 0);
    check("arst done", done, 0);
    check("arst ovf", overflow, 0);
    check("arst unf", underflow, 0);
    seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    check("arst no done", seen, 0);
    rst_n = 1'b1;
    do_op(32'h40400000, 32'h40200000, mk(32'h40F00000, 0, 0, 0), "post-rst");

    for (int i = 0; i < 60; i++) begin
      logic [31:0] ra, rb;
      ra = rand_op();
      rb = rand_op();
      e  = model(ra, rb);
      do_op(ra, rb, e, $sformatf("rand%0d %h*%h", i, ra, rb));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
